led_bar_driver: RTL and testbench
=================================

# led_bar_driver

Parametrised LED bar and alarm indicator driver for the lock (Zamek) front panel. It shows code-entry progress as a thermometer bar of `N_LED` LEDs and generates its own blink timing. It runs an alarm sequence: latched alarm, strobe, and a hold-off period after clearing. It sits between the lock controller FSM and the board LED pins.

## Interface
- `N_LED`, 4: number of bar LEDs (1..16).
- `BLINK_DIV`, 25_000_000: clock cycles per blink half-period (≥2).
- `STROBE_DIV`, 5_000_000: clock cycles per alarm strobe half-period (≥2).
- `ALARM_HOLD`, 50_000_000: cycles the alarm LED stays steady-on after clearing (≥1).
- `LW`, derived = $clog2(N_LED+1): width of `level`.
---
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `level` in LW: number of lit bar LEDs, LSB first.
- `mode` in 2: 00 off, 01 steady, 10 blink, 11 reserved (treated as off).
- `alarm_req` in 1: level alarm request from the lock FSM.
- `alarm_clr` in 1: alarm acknowledge/clear.
- `led` out N_LED: bar LED drive, active-high.
- `alarm_led` out 1: alarm LED drive.
- `alarm_active` out 1: high in states ALARM and HOLD.
- `cmd_err` out 1: one-cycle pulse when `level` > `N_LED` is sampled.

## Operation
- **Bar pattern:**
  - `bar = (1<<level)-1` for `level` ≤ `N_LED`.
  - For `level` > `N_LED`, `bar = 0` and `cmd_err` pulses each cycle the condition holds.
- **Blink generator:**
  - Counter `0..BLINK_DIV-1`; the phase bit toggles on wrap.
  - On entry into mode 10 (previous cycle's mode ≠ 10), the counter clears and the phase is set to on, so the first on-period is full length.
- **Normal output:**
  - mode 00/11: `led = 0`.
  - mode 01: `led = bar`.
  - mode 10: `led = bar & {N_LED{phase}}`.
- **Alarm FSM (IDLE, ALARM, HOLD):**
  - IDLE → ALARM when `alarm_req` = 1.
  - ALARM: the strobe counter runs and `strobe` toggles every `STROBE_DIV` cycles, starting at 1.
    - `alarm_led = strobe`.
    - `led = {N_LED{strobe}}`, overriding mode and level.
    - ALARM → HOLD when `alarm_clr` = 1 and `alarm_req` = 0.
  - HOLD: `alarm_led = 1`; `led` returns to normal output; the hold counter counts `ALARM_HOLD` cycles.
    - HOLD → ALARM if `alarm_req` = 1; the strobe restarts at 1.
    - HOLD → IDLE when the count expires.
  - Simultaneous `alarm_req` and `alarm_clr`: the request wins (stay in or enter ALARM).
  - `alarm_clr` in IDLE has no effect.

## Timing
- All outputs are registered; input-to-output latency is 1 cycle.
- Reset values:
  - `led` = 0, `alarm_led` = 0, `alarm_active` = 0, `cmd_err` = 0.
  - FSM = IDLE, all counters 0, blink phase = on, strobe = 1.
- Reset mid-alarm: outputs go dark immediately (asynchronous); the FSM returns to IDLE. A still-asserted `alarm_req` re-enters ALARM on the first clock after release.
- Counter wrap: the blink phase toggles on the cycle the counter equals `BLINK_DIV-1`. The blink counter free-runs in every mode and every FSM state.
- HOLD lasts exactly `ALARM_HOLD` cycles: `alarm_active` drops `ALARM_HOLD` cycles after the HOLD entry cycle.

## Configuration
- Macro: `LED_BAR_PWM_EN`.
- **Defined:**
  - Adds parameter `PWM_BITS` (default 4) and input `duty [PWM_BITS-1:0]`.
  - A free-running `PWM_BITS` counter produces `pwm_on = (cnt < duty)`.
  - Bar LEDs are ANDed with `pwm_on` in all normal modes.
  - `duty` = 0 gives a dark bar; `duty` = all-ones gives 2^PWM_BITS-1 on-cycles out of 2^PWM_BITS.
  - Alarm strobe and `alarm_led` are never dimmed.
- **Undefined:** no `duty` port, no PWM logic; the bar is full brightness.

## Structure
- Package `led_bar_pkg`:
  - `mode_t` enum: `MODE_OFF`, `MODE_STEADY`, `MODE_BLINK`, `MODE_RSVD`.
  - `alarm_st_t` enum: `ST_IDLE`, `ST_ALARM`, `ST_HOLD`.
  - Helper function `therm(level, n)`.
- Sub-module `led_tick_div`:
  - Parameter `DIV`; ports `clk`, `rst_n`, `restart`, `tick`.
  - Modulo counter with synchronous restart.
  - Instantiated for the blink and strobe timing.
- The hold counter is local to `led_bar_driver`.

## Test plan
All scenarios use N_LED=4, BLINK_DIV=4, STROBE_DIV=2, ALARM_HOLD=8.
- level=3, mode=01 → `led` = 4'b0111 one cycle later; level=5 → `led` = 0 and `cmd_err` high while applied.
- level=4, mode 00→10 → `led` = 4'b1111 for 4 cycles, 4'b0000 for 4 cycles, repeating.
- `alarm_req` pulse, level=2 steady → `alarm_active`=1, and `led`/`alarm_led` alternate 1111/1 and 0000/0 every 2 cycles.
- `alarm_clr`=1 with `alarm_req`=0 → HOLD: `alarm_led`=1 and `led`=4'b0011 for 8 cycles, then `alarm_active`=0 and `alarm_led`=0.
- `alarm_req` and `alarm_clr` both high for 5 cycles → remains in ALARM, strobing.
- `rst_n` low mid-ALARM → all outputs 0 asynchronously; release with `alarm_req`=1 → `alarm_active`=1 one cycle after the first clock.

Source files
------------

// File: rtl/led_bar_pkg.sv
// Shared types and the thermometer helper for the LED bar driver.
package led_bar_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_STEADY = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALARM = 2'd1,
    ST_HOLD  = 2'd2
  } alarm_st_t;

  // Lowest `level` bits set; an out-of-range level gives an empty bar.
  function automatic logic [15:0] therm(input int unsigned level, input int unsigned n);
    logic [31:0] t;
    if (level > n) t = '0;
    else           t = (32'd1 << level) - 32'd1;
    return t[15:0];
  endfunction

endpackage

// File: rtl/led_tick_div.sv
// Modulo-DIV counter; tick is high on the last count, restart clears synchronously.
module led_tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_bar_driver.sv
// Thermometer LED bar with blink and alarm strobe/hold sequencing.
// Optional PWM dimming of the bar when LED_BAR_PWM_EN is defined.
module led_bar_driver
  import led_bar_pkg::*;
#(
  parameter int N_LED      = 4,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int STROBE_DIV = 5_000_000,
  parameter int ALARM_HOLD = 50_000_000,
`ifdef LED_BAR_PWM_EN
  parameter int PWM_BITS   = 4,
`endif
  parameter int LW         = $clog2(N_LED + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LW-1:0]    level,
  input  logic [1:0]       mode,
  input  logic             alarm_req,
  input  logic             alarm_clr,
`ifdef LED_BAR_PWM_EN
  input  logic [PWM_BITS-1:0] duty,
`endif
  output logic [N_LED-1:0] led,
  output logic             alarm_led,
  output logic             alarm_active,
  output logic             cmd_err
);
  localparam int HW = $clog2(ALARM_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ALARM_HOLD - 1);

  alarm_st_t        st_q, st_d;
  mode_t            mode_s, mode_prev_q;
  logic [HW-1:0]    hold_q, hold_d;
  logic             phase_q, phase_d, strobe_q, strobe_d;
  logic [N_LED-1:0] led_q, led_d, bar, normal;
  logic             alarm_led_q, alarm_led_d, active_q, active_d, cmd_err_q, cmd_err_d;
  logic             blink_restart, blink_tick, strobe_restart, strobe_tick, pwm_on;

  assign mode_s = mode_t'(mode);
  assign bar    = N_LED'(therm(int'(level), N_LED));

  led_tick_div #(.DIV(BLINK_DIV)) u_blink (
    .clk(clk), .rst_n(rst_n), .restart(blink_restart), .tick(blink_tick));
  led_tick_div #(.DIV(STROBE_DIV)) u_strobe (
    .clk(clk), .rst_n(rst_n), .restart(strobe_restart), .tick(strobe_tick));

`ifdef LED_BAR_PWM_EN
  logic [PWM_BITS-1:0] pwm_q;
  assign pwm_on = (pwm_q < duty);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= '0;
    else        pwm_q <= pwm_q + 1'b1;
  end
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    st_d           = st_q;
    hold_d         = hold_q;
    strobe_restart = 1'b0;
    blink_restart  = (mode_s == MODE_BLINK) && (mode_prev_q != MODE_BLINK);

    phase_d = phase_q;
    if (blink_restart)   phase_d = 1'b1;
    else if (blink_tick) phase_d = ~phase_q;

    case (st_q)
      ST_IDLE:  if (alarm_req) begin st_d = ST_ALARM; strobe_restart = 1'b1; end
      ST_ALARM: if (alarm_clr && !alarm_req) begin st_d = ST_HOLD; hold_d = '0; end
      ST_HOLD: begin
        if (alarm_req) begin st_d = ST_ALARM; strobe_restart = 1'b1; end
        else if (hold_q == HOLD_LAST) st_d = ST_IDLE;
        else hold_d = hold_q + 1'b1;
      end
      default: st_d = ST_IDLE;
    endcase

    strobe_d = strobe_q;
    if (strobe_restart)                       strobe_d = 1'b1;
    else if (st_q == ST_ALARM && strobe_tick) strobe_d = ~strobe_q;

    // Outputs are computed from next-state values so they register in one cycle.
    case (mode_s)
      MODE_STEADY: normal = bar;
      MODE_BLINK:  normal = bar & {N_LED{phase_d}};
      default:     normal = '0;
    endcase
    normal = normal & {N_LED{pwm_on}};

    led_d       = (st_d == ST_ALARM) ? {N_LED{strobe_d}} : normal;
    alarm_led_d = (st_d == ST_ALARM) ? strobe_d : (st_d == ST_HOLD);
    active_d    = (st_d != ST_IDLE);
    cmd_err_d   = (int'(level) > N_LED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_IDLE;
      mode_prev_q <= MODE_OFF;
      hold_q      <= '0;
      phase_q     <= 1'b1;
      strobe_q    <= 1'b1;
      led_q       <= '0;
      alarm_led_q <= 1'b0;
      active_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      mode_prev_q <= mode_s;
      hold_q      <= hold_d;
      phase_q     <= phase_d;
      strobe_q    <= strobe_d;
      led_q       <= led_d;
      alarm_led_q <= alarm_led_d;
      active_q    <= active_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign led          = led_q;
  assign alarm_led    = alarm_led_q;
  assign alarm_active = active_q;
  assign cmd_err      = cmd_err_q;
endmodule

// File: tb/tb_led_bar_driver.sv
// Directed bench for led_bar_driver with N_LED=4, BLINK_DIV=4, STROBE_DIV=2, ALARM_HOLD=8.
module tb_led_bar_driver;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] level;
  logic [1:0] mode;
  logic       alarm_req, alarm_clr;
`ifdef LED_BAR_PWM_EN
  logic [3:0] duty = 4'hF;
`endif
  logic [3:0] led;
  logic       alarm_led, alarm_active, cmd_err;

  int n_cmp = 0;
  int n_err = 0;

  led_bar_driver #(.N_LED(4), .BLINK_DIV(4), .STROBE_DIV(2), .ALARM_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .level(level), .mode(mode),
    .alarm_req(alarm_req), .alarm_clr(alarm_clr),
`ifdef LED_BAR_PWM_EN
    .duty(duty),
`endif
    .led(led), .alarm_led(alarm_led), .alarm_active(alarm_active), .cmd_err(cmd_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all four outputs at once.
  task automatic chk_all(input string tag, input logic [3:0] e_led, input logic e_al,
                         input logic e_act, input logic e_err);
    chk({tag, ".led"}, 32'(led), 32'(e_led));
    chk({tag, ".alarm_led"}, 32'(alarm_led), 32'(e_al));
    chk({tag, ".alarm_active"}, 32'(alarm_active), 32'(e_act));
    chk({tag, ".cmd_err"}, 32'(cmd_err), 32'(e_err));
  endtask

  initial begin
    rst_n = 1'b0; level = 3'd0; mode = 2'b00; alarm_req = 1'b0; alarm_clr = 1'b0;
    #1;
    chk_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;

    // Steady bar and out-of-range level
    level = 3'd3; mode = 2'b01; tick();
    chk_all("steady3", 4'b0111, 1'b0, 1'b0, 1'b0);
    level = 3'd5; tick();
    chk_all("lvl5_a", 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("lvl5_b", 4'b0000, 1'b0, 1'b0, 1'b1);
    level = 3'd0; tick();
    chk_all("steady0", 4'b0000, 1'b0, 1'b0, 1'b0);
    level = 3'd4; tick();
    chk("steady4", 32'(led), 32'hF);
    mode = 2'b11; tick();
    chk("rsvd", 32'(led), 32'h0);

    // Blink: full on-period from entry, then 4 off, repeating
    mode = 2'b00; tick();
    chk("off", 32'(led), 32'h0);
    mode = 2'b10;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("blink%0d", i), 32'(led), ((i / 4) % 2 == 0) ? 32'hF : 32'h0);
    end

    // Alarm strobe with level=2 steady underneath
    mode = 2'b01; level = 3'd2; tick();
    chk("pre_alarm", 32'(led), 32'h3);
    alarm_req = 1'b1; tick();
    chk_all("strobe0", 4'b1111, 1'b1, 1'b1, 1'b0);
    alarm_req = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      if ((i / 2) % 2 == 0) chk_all($sformatf("strobe%0d", i), 4'b1111, 1'b1, 1'b1, 1'b0);
      else                  chk_all($sformatf("strobe%0d", i), 4'b0000, 1'b0, 1'b1, 1'b0);
    end

    // Clear -> HOLD for exactly 8 cycles
    alarm_clr = 1'b1; tick();
    chk_all("hold0", 4'b0011, 1'b1, 1'b1, 1'b0);
    alarm_clr = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_all($sformatf("hold%0d", i), 4'b0011, 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk_all("hold_done", 4'b0011, 1'b0, 1'b0, 1'b0);

    // Request and clear together: request wins
    alarm_req = 1'b1; alarm_clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ((i / 2) % 2 == 0) chk_all($sformatf("both%0d", i), 4'b1111, 1'b1, 1'b1, 1'b0);
      else                  chk_all($sformatf("both%0d", i), 4'b0000, 1'b0, 1'b1, 1'b0);
    end
    alarm_req = 1'b0; tick();
    chk_all("hold_b0", 4'b0011, 1'b1, 1'b1, 1'b0);
    alarm_clr = 1'b0; tick();
    chk_all("hold_b1", 4'b0011, 1'b1, 1'b1, 1'b0);

    // Re-request from HOLD restarts strobe at 1
    alarm_req = 1'b1; tick();
    chk_all("rearm0", 4'b1111, 1'b1, 1'b1, 1'b0);
    alarm_req = 1'b0; tick();
    chk_all("rearm1", 4'b1111, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("rearm2", 4'b0000, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-alarm, request still asserted
    alarm_req = 1'b1; tick();
    chk("pre_rst_active", 32'(alarm_active), 32'h1);
    rst_n = 1'b0; #1;
    chk_all("async_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("in_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; tick();
    chk_all("post_rst0", 4'b1111, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("post_rst1", 4'b1111, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
